// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2
  } gate_state_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam int unsigned DEFAULT_CAPACITY      = 8;
  localparam int unsigned DEFAULT_GATE_OPEN_MS  = 2000;
  localparam int unsigned DEFAULT_CLK_FREQUENCY = 40_000_000;

endpackage

// File: rtl/gate_hold_timer.sv
// Hold timer: start begins a run of OPEN_CYCLES counts (0..OPEN_CYCLES-1);
// done flags the final count.
module gate_hold_timer #(
  parameter int unsigned OPEN_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int unsigned CW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(OPEN_CYCLES - 1);

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
    end else if (active_q) begin
      if (cnt_q == LAST) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done = active_q && (cnt_q == LAST);

endmodule

// File: rtl/parking_gate_controller.sv
// Lot occupancy tracker driving a single shared barrier gate, with
// one-deep per-direction request queueing and exit-over-entry priority.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY      = DEFAULT_CAPACITY,
  parameter int unsigned CLK_FREQUENCY = DEFAULT_CLK_FREQUENCY,
  parameter int unsigned GATE_OPEN_MS  = DEFAULT_GATE_OPEN_MS,
  localparam int unsigned OPEN_CYCLES  = CLK_FREQUENCY / 1000 * GATE_OPEN_MS,
  localparam int unsigned OCC_W        = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entryPulse,
  input  logic             exitPulse,
  output logic             gateOpen,
  output logic             gateDir,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             rejectPulse,
  output logic             faultPulse
);

  localparam logic [OCC_W-1:0] CAP_OCC = OCC_W'(CAPACITY);

  gate_state_t      state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             entry_pend_q, entry_pend_d;
  logic             exit_pend_q, exit_pend_d;
  logic             gate_open_q, gate_open_d;
  logic             gate_dir_q, gate_dir_d;
  logic             reject_q, reject_d;
  logic             fault_q, fault_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  logic timer_start;
  logic timer_done;
  logic entry_req;
  logic exit_req;

  gate_hold_timer #(
    .OPEN_CYCLES(OPEN_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .reset(reset),
    .start(timer_start),
    .done (timer_done)
  );

  assign entry_req = entryPulse | entry_pend_q;
  assign exit_req  = exitPulse | exit_pend_q;

  always_comb begin
    state_d      = state_q;
    occ_d        = occ_q;
    entry_pend_d = entry_pend_q;
    exit_pend_d  = exit_pend_q;
    gate_open_d  = gate_open_q;
    gate_dir_d   = gate_dir_q;
    reject_d     = 1'b0;
    fault_d      = 1'b0;
    timer_start  = 1'b0;

    case (state_q)
      IDLE: begin
        if (exit_req) begin
          // Exit wins; a same-cycle entry request is parked in its flag.
          exit_pend_d  = 1'b0;
          entry_pend_d = entry_req;
          if (occ_q != '0) begin
            state_d     = OPEN_OUT;
            occ_d       = occ_q - OCC_W'(1);
            gate_open_d = 1'b1;
            gate_dir_d  = DIR_OUT;
            timer_start = 1'b1;
          end else begin
            fault_d = 1'b1;
          end
        end else if (entry_req) begin
          entry_pend_d = 1'b0;
          if (occ_q < CAP_OCC) begin
            state_d     = OPEN_IN;
            occ_d       = occ_q + OCC_W'(1);
            gate_open_d = 1'b1;
            gate_dir_d  = DIR_IN;
            timer_start = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      OPEN_IN, OPEN_OUT: begin
        if (entryPulse) entry_pend_d = 1'b1;
        if (exitPulse)  exit_pend_d  = 1'b1;
        if (timer_done) begin
          state_d     = IDLE;
          gate_open_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        gate_open_d = 1'b0;
      end
    endcase

    full_d  = (occ_d == CAP_OCC);
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      occ_q        <= '0;
      entry_pend_q <= 1'b0;
      exit_pend_q  <= 1'b0;
      gate_open_q  <= 1'b0;
      gate_dir_q   <= DIR_IN;
      reject_q     <= 1'b0;
      fault_q      <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      entry_pend_q <= entry_pend_d;
      exit_pend_q  <= exit_pend_d;
      gate_open_q  <= gate_open_d;
      gate_dir_q   <= gate_dir_d;
      reject_q     <= reject_d;
      fault_q      <= fault_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
    end
  end

  assign gateOpen    = gate_open_q;
  assign gateDir     = gate_dir_q;
  assign occupancy   = occ_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign rejectPulse = reject_q;
  assign faultPulse  = fault_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller: CAPACITY=2, OPEN_CYCLES=4.
module tb_parking_gate_controller;

  logic       clk;
  logic       reset;
  logic       entryPulse;
  logic       exitPulse;
  logic       gateOpen;
  logic       gateDir;
  logic [1:0] occupancy;
  logic       full;
  logic       empty;
  logic       rejectPulse;
  logic       faultPulse;

  int total;
  int bad;

  parking_gate_controller #(
    .CAPACITY     (2),
    .CLK_FREQUENCY(1000),
    .GATE_OPEN_MS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .entryPulse (entryPulse),
    .exitPulse  (exitPulse),
    .gateOpen   (gateOpen),
    .gateDir    (gateDir),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .rejectPulse(rejectPulse),
    .faultPulse (faultPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Covers the remaining three open cycles after the service edge, then the close.
  task automatic hold_rest(input logic dir, input string tag);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk({tag, "_open"}, {31'd0, gateOpen}, 32'd1);
      chk({tag, "_dir"}, {31'd0, gateDir}, {31'd0, dir});
    end
    tick();
    chk({tag, "_closed"}, {31'd0, gateOpen}, 32'd0);
  endtask

  task automatic pulse(input logic en, input logic ex);
    entryPulse = en;
    exitPulse  = ex;
    tick();
    entryPulse = 1'b0;
    exitPulse  = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    entryPulse = 1'b0;
    exitPulse  = 1'b0;
    tick();
    tick();

    chk("rst_gate",   {31'd0, gateOpen},    32'd0);
    chk("rst_dir",    {31'd0, gateDir},     32'd0);
    chk("rst_occ",    {30'd0, occupancy},   32'd0);
    chk("rst_full",   {31'd0, full},        32'd0);
    chk("rst_empty",  {31'd0, empty},       32'd1);
    chk("rst_reject", {31'd0, rejectPulse}, 32'd0);
    chk("rst_fault",  {31'd0, faultPulse},  32'd0);

    reset = 1'b0;
    tick();
    tick();

    // Single entry
    pulse(1'b1, 1'b0);
    chk("e1_gate",  {31'd0, gateOpen},  32'd1);
    chk("e1_dir",   {31'd0, gateDir},   32'd0);
    chk("e1_occ",   {30'd0, occupancy}, 32'd1);
    chk("e1_empty", {31'd0, empty},     32'd0);
    chk("e1_full",  {31'd0, full},      32'd0);
    hold_rest(1'b0, "e1");

    // Fill then overflow
    pulse(1'b1, 1'b0);
    chk("e2_occ",  {30'd0, occupancy}, 32'd2);
    chk("e2_full", {31'd0, full},      32'd1);
    hold_rest(1'b0, "e2");
    pulse(1'b1, 1'b0);
    chk("e3_reject", {31'd0, rejectPulse}, 32'd1);
    chk("e3_gate",   {31'd0, gateOpen},    32'd0);
    chk("e3_occ",    {30'd0, occupancy},   32'd2);
    chk("e3_full",   {31'd0, full},        32'd1);
    tick();
    chk("e3_reject_off", {31'd0, rejectPulse}, 32'd0);
    chk("e3_gate_off",   {31'd0, gateOpen},    32'd0);

    // Bring occupancy to 1
    pulse(1'b0, 1'b1);
    chk("x1_gate", {31'd0, gateOpen},  32'd1);
    chk("x1_dir",  {31'd0, gateDir},   32'd1);
    chk("x1_occ",  {30'd0, occupancy}, 32'd1);
    chk("x1_full", {31'd0, full},      32'd0);
    hold_rest(1'b1, "x1");

    // Simultaneous entry and exit: exit first, one-cycle gap, then entry
    pulse(1'b1, 1'b1);
    chk("sim_x_gate",  {31'd0, gateOpen},  32'd1);
    chk("sim_x_dir",   {31'd0, gateDir},   32'd1);
    chk("sim_x_occ",   {30'd0, occupancy}, 32'd0);
    chk("sim_x_empty", {31'd0, empty},     32'd1);
    hold_rest(1'b1, "sim_x");
    tick();
    chk("sim_e_gate", {31'd0, gateOpen},  32'd1);
    chk("sim_e_dir",  {31'd0, gateDir},   32'd0);
    chk("sim_e_occ",  {30'd0, occupancy}, 32'd1);
    hold_rest(1'b0, "sim_e");

    // Empty the lot, then exit with nobody inside
    pulse(1'b0, 1'b1);
    chk("x2_occ", {30'd0, occupancy}, 32'd0);
    hold_rest(1'b1, "x2");
    pulse(1'b0, 1'b1);
    chk("flt_pulse", {31'd0, faultPulse}, 32'd1);
    chk("flt_gate",  {31'd0, gateOpen},   32'd0);
    chk("flt_occ",   {30'd0, occupancy},  32'd0);
    tick();
    chk("flt_pulse_off", {31'd0, faultPulse}, 32'd0);
    chk("flt_gate_off",  {31'd0, gateOpen},   32'd0);

    // Requests during a hold: two entries (one dropped) and one exit
    pulse(1'b1, 1'b0);
    chk("q_e_occ", {30'd0, occupancy}, 32'd1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    chk("q_hold_open", {31'd0, gateOpen}, 32'd1);
    tick();
    chk("q_gap1", {31'd0, gateOpen}, 32'd0);
    tick();
    chk("q_x_gate", {31'd0, gateOpen},  32'd1);
    chk("q_x_dir",  {31'd0, gateDir},   32'd1);
    chk("q_x_occ",  {30'd0, occupancy}, 32'd0);
    hold_rest(1'b1, "q_x");
    tick();
    chk("q_e2_gate", {31'd0, gateOpen},  32'd1);
    chk("q_e2_dir",  {31'd0, gateDir},   32'd0);
    chk("q_e2_occ",  {30'd0, occupancy}, 32'd1);
    hold_rest(1'b0, "q_e2");
    tick();
    tick();
    tick();
    chk("q_no_dup_gate", {31'd0, gateOpen},  32'd0);
    chk("q_no_dup_occ",  {30'd0, occupancy}, 32'd1);

    // Reset during the second hold cycle
    pulse(1'b1, 1'b0);
    chk("r_pre_occ", {30'd0, occupancy}, 32'd2);
    tick();
    chk("r_pre_gate", {31'd0, gateOpen}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("r_async_gate",  {31'd0, gateOpen},  32'd0);
    chk("r_async_occ",   {30'd0, occupancy}, 32'd0);
    chk("r_async_empty", {31'd0, empty},     32'd1);
    chk("r_async_full",  {31'd0, full},      32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("r_post_reject", {31'd0, rejectPulse}, 32'd0);
    chk("r_post_fault",  {31'd0, faultPulse},  32'd0);
    chk("r_post_gate",   {31'd0, gateOpen},    32'd0);
    pulse(1'b1, 1'b0);
    chk("r_e_gate",  {31'd0, gateOpen},  32'd1);
    chk("r_e_dir",   {31'd0, gateDir},   32'd0);
    chk("r_e_occ",   {30'd0, occupancy}, 32'd1);
    chk("r_e_empty", {31'd0, empty},     32'd0);
    hold_rest(1'b0, "r_e");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
